pulse_analyzer: RTL and testbench

Receive-side measurement block for the synthesizer's 12-bit sample stream. It consumes the samples the synthesizer drives on its output and detects each radio pulse by amplitude threshold. For every pulse it measures width, start-to-start period and carrier cycle count, and hands the results out one report at a time on a valid/ready interface. It sits on the loopback/verification path after the output register and checks generated bursts against the programmed T_IMPULSE, T_PERIOD, NUM_OF_IMP and F_CARRIER.

---
 rtl/synth_meas_pkg.sv | 13 +
 rtl/envelope_detector.sv | 46 ++++
 rtl/pulse_analyzer.sv | 171 +++++++++++++++++
 tb/tb_pulse_analyzer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_meas_pkg.sv
// Shared definitions for the synthesizer loopback measurement path.
package synth_meas_pkg;
  localparam logic [11:0] MIDSCALE  = 12'd2048;
  localparam int          CNT_W_DEF = 20;
  localparam int          ZC_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PULSE,
    ST_REPORT
  } state_e;
endpackage

// File: rtl/envelope_detector.sv
// Input register plus amplitude-threshold and upward-midscale-crossing flags.
// All outputs describe the registered sample (one cycle behind the input).
module envelope_detector
  import synth_meas_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [11:0] i_sample,
  input  logic [10:0] i_threshold,
  output logic        o_valid,
  output logic        o_active,
  output logic        o_sign,
  output logic        o_rise
);
  logic [11:0] r_sample;
  logic        r_valid;
  logic        r_prev_sign;
  logic        w_sign;
  logic [11:0] w_diff;
  logic [10:0] w_abs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample    <= MIDSCALE;
      r_valid     <= 1'b0;
      r_prev_sign <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_sample <= i_sample;
      if (r_valid) r_prev_sign <= w_sign;
    end
  end

  // Sample 0 is 2048 below midscale, which does not fit in 11 bits.
  always_comb begin
    w_sign = (r_sample >= MIDSCALE);
    w_diff = w_sign ? (r_sample - MIDSCALE) : (MIDSCALE - r_sample);
    w_abs  = w_diff[11] ? 11'h7FF : w_diff[10:0];
  end

  assign o_valid  = r_valid;
  assign o_sign   = w_sign;
  assign o_active = (w_abs > i_threshold);
  assign o_rise   = r_valid & w_sign & ~r_prev_sign;
endmodule

// File: rtl/pulse_analyzer.sv
// Pulse detector: measures width, start-to-start period and carrier cycles of
// each pulse in an armed burst and hands reports out on a valid/ready port.
module pulse_analyzer
  import synth_meas_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ZC_W    = ZC_W_DEF,
  parameter int GAP_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_arm,
  input  logic [4:0]       i_num_of_imp,
  input  logic [10:0]      i_threshold,
  input  logic             i_sample_valid,
  input  logic [11:0]      i_sample_in,
  output logic             o_report_valid,
  input  logic             i_report_ready,
  output logic [CNT_W-1:0] o_meas_width,
  output logic [CNT_W-1:0] o_meas_period,
  output logic [ZC_W-1:0]  o_meas_cycles,
  output logic [4:0]       o_meas_index,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun
);
  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [ZC_W-1:0] inc_z(input logic [ZC_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  logic w_v, w_act, w_sign, w_rise;

  envelope_detector u_env (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_sample_valid),
    .i_sample    (i_sample_in),
    .i_threshold (i_threshold),
    .o_valid     (w_v),
    .o_active    (w_act),
    .o_sign      (w_sign),
    .o_rise      (w_rise)
  );

  state_e           r_state, w_state_n;
  logic [4:0]       r_num, r_idx;
  logic             r_first, r_in_pulse;
  logic [CNT_W-1:0] r_pcnt, r_per, r_width, r_len, r_gap;
  logic [ZC_W-1:0]  r_cyc;

  logic             w_start, w_track, w_done_pulse, w_accept, w_last;
  logic             w_load, w_ovr_set;
  logic [CNT_W-1:0] w_len_n, w_gap_n;
  logic [ZC_W-1:0]  w_cyc_n;

  // A pulse can begin in REPORT too; it is tracked in the background.
  always_comb begin
    w_start      = w_v & w_act &
                   ((r_state == ST_WAIT) | ((r_state == ST_REPORT) & ~r_in_pulse));
    w_track      = (r_state == ST_PULSE) | ((r_state == ST_REPORT) & r_in_pulse);
    w_len_n      = inc_c(r_len);
    w_gap_n      = inc_c(r_gap);
    w_cyc_n      = w_rise ? inc_z(r_cyc) : r_cyc;
    w_done_pulse = w_track & w_v & ~w_act & (w_gap_n == CNT_W'(GAP_LEN));
    w_accept     = o_report_valid & i_report_ready;
    w_last       = w_accept & (r_idx == (r_num - 5'd1));
    w_load       = ((r_state == ST_PULSE) & w_done_pulse) |
                   (w_accept & ~w_last & w_done_pulse);
    w_ovr_set    = (r_state == ST_REPORT) & ~w_accept & w_done_pulse;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE:   w_state_n = ST_IDLE;
      ST_WAIT:   if (w_start) w_state_n = ST_PULSE;
      ST_PULSE:  if (w_done_pulse) w_state_n = ST_REPORT;
      ST_REPORT: begin
        if (w_accept) begin
          if (w_last)                      w_state_n = ST_IDLE;
          else if (w_done_pulse)           w_state_n = ST_REPORT;
          else if (r_in_pulse || w_start)  w_state_n = ST_PULSE;
          else                             w_state_n = ST_WAIT;
        end
      end
      default:   w_state_n = ST_IDLE;
    endcase
    if (i_arm) w_state_n = ST_WAIT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num          <= '0;
      r_idx          <= '0;
      r_first        <= 1'b0;
      r_in_pulse     <= 1'b0;
      r_pcnt         <= '0;
      r_per          <= '0;
      r_width        <= '0;
      r_len          <= '0;
      r_gap          <= '0;
      r_cyc          <= '0;
      o_report_valid <= 1'b0;
      o_meas_width   <= '0;
      o_meas_period  <= '0;
      o_meas_cycles  <= '0;
      o_meas_index   <= '0;
      o_done         <= 1'b0;
      o_overrun      <= 1'b0;
    end else if (i_arm) begin
      r_num          <= i_num_of_imp;
      r_idx          <= '0;
      r_first        <= 1'b1;
      r_in_pulse     <= 1'b0;
      r_pcnt         <= '0;
      o_report_valid <= 1'b0;
      o_done         <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      if ((r_state != ST_IDLE) && w_v)
        r_pcnt <= w_start ? CNT_W'(1) : inc_c(r_pcnt);

      if (w_start) begin
        r_per   <= r_first ? '0 : r_pcnt;
        r_first <= 1'b0;
        r_width <= CNT_W'(1);
        r_len   <= CNT_W'(1);
        r_cyc   <= '0;
        r_gap   <= '0;
      end else if (w_track && w_v) begin
        r_len <= w_len_n;
        r_cyc <= w_cyc_n;
        if (w_act) begin
          r_gap   <= '0;
          r_width <= w_len_n;
        end else begin
          r_gap <= w_gap_n;
        end
      end

      if ((r_state == ST_REPORT) && w_start && !w_accept) r_in_pulse <= 1'b1;
      else if (w_done_pulse || w_accept)                  r_in_pulse <= 1'b0;

      // Trailing quiet samples never move width, so r_width is final here.
      if (w_load) begin
        o_report_valid <= 1'b1;
        o_meas_width   <= r_width;
        o_meas_period  <= r_per;
        o_meas_cycles  <= w_cyc_n;
        o_meas_index   <= w_accept ? (r_idx + 5'd1) : r_idx;
      end else if (w_accept) begin
        o_report_valid <= 1'b0;
      end

      if (w_accept)  r_idx     <= r_idx + 5'd1;
      if (w_last)    o_done    <= 1'b1;
      if (w_ovr_set) o_overrun <= 1'b1;
    end
  end

  assign o_busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_pulse_analyzer.sv
// Directed and randomized checks of pulse_analyzer against a sample-list model.
module tb_pulse_analyzer;
  localparam int GL = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_arm = 1'b0;
  logic [4:0]  i_num_of_imp = '0;
  logic [10:0] i_threshold = 11'd100;
  logic        i_sample_valid = 1'b0;
  logic [11:0] i_sample_in = 12'd2048;
  logic        i_report_ready = 1'b0;
  logic        o_report_valid, o_busy, o_done, o_overrun;
  logic [19:0] o_meas_width, o_meas_period;
  logic [15:0] o_meas_cycles;
  logic [4:0]  o_meas_index;

  pulse_analyzer #(.CNT_W(20), .ZC_W(16), .GAP_LEN(GL)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_arm          (i_arm),
    .i_num_of_imp   (i_num_of_imp),
    .i_threshold    (i_threshold),
    .i_sample_valid (i_sample_valid),
    .i_sample_in    (i_sample_in),
    .o_report_valid (o_report_valid),
    .i_report_ready (i_report_ready),
    .o_meas_width   (o_meas_width),
    .o_meas_period  (o_meas_period),
    .o_meas_cycles  (o_meas_cycles),
    .o_meas_index   (o_meas_index),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_overrun      (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int w; int p; int c; int i;} rep_t;
  rep_t got_q[$];
  rep_t exp_q[$];
  int   vs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always @(negedge i_clk)
    if (i_rst_n && !i_arm && o_report_valid && i_report_ready)
      got_q.push_back('{int'(o_meas_width), int'(o_meas_period),
                        int'(o_meas_cycles), int'(o_meas_index)});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int s);
    i_sample_valid = v;
    i_sample_in    = s[11:0];
    if (v) vs.push_back(s);
    @(posedge i_clk);
    #1;
    i_arm = 1'b0;
  endtask

  task automatic run(input int n, input int s);
    for (int k = 0; k < n; k++) step(1'b1, s);
  endtask

  task automatic arm(input int n);
    i_arm        = 1'b1;
    i_num_of_imp = n[4:0];
    vs.delete();
    got_q.delete();
    exp_q.delete();
    step(1'b1, 2048);
  endtask

  function automatic bit sgn(input int s);
    return s >= 2048;
  endfunction

  function automatic int absv(input int s);
    int a;
    a = (s >= 2048) ? s - 2048 : 2048 - s;
    return (a > 2047) ? 2047 : a;
  endfunction

  // Walks the list of valid samples with the pulse rules; assumes no backpressure.
  task automatic run_model(input int thr, input int n);
    bit in_p = 0, first = 1;
    int start = 0, last = 0, prev = 0, cyc = 0, gap = 0, per = 0, idx = 0;
    int nn;
    nn = (n == 0) ? 32 : n;
    for (int k = 0; k < vs.size(); k++) begin
      bit act;
      act = absv(vs[k]) > thr;
      if (!in_p) begin
        if (act) begin
          in_p = 1; start = k; last = k; cyc = 0; gap = 0;
          per = first ? 0 : k - prev;
          first = 0; prev = k;
        end
      end else begin
        if (sgn(vs[k]) && !sgn(vs[k-1])) cyc++;
        if (act) begin
          gap = 0; last = k;
        end else begin
          gap++;
          if (gap == GL) begin
            exp_q.push_back('{last - start + 1, per, cyc, idx});
            idx++; in_p = 0;
            if (idx == nn) break;
          end
        end
      end
    end
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk($sformatf("%s[%0d].width", tag, k),  got_q[k].w, exp_q[k].w);
      chk($sformatf("%s[%0d].period", tag, k), got_q[k].p, exp_q[k].p);
      chk($sformatf("%s[%0d].cycles", tag, k), got_q[k].c, exp_q[k].c);
      chk($sformatf("%s[%0d].index", tag, k),  got_q[k].i, exp_q[k].i);
    end
  endtask

  task automatic sq_burst(input bit toggle);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 1000; k++) begin
        int s;
        s = (k < 200) ? ((((k / 4) % 2) == 0) ? 1000 : 3000) : 2048;
        if (toggle) step(1'b0, int'($urandom_range(0, 4095)));
        step(1'b1, s);
      end
  endtask

  function automatic int gen(input int thr, input bit active);
    int mag;
    mag = active ? int'($urandom_range(thr + 1, 2047)) : int'($urandom_range(0, thr));
    return ($urandom_range(0, 1) != 0) ? 2048 + mag : 2048 - mag;
  endfunction

  task automatic chk_q_const(input string tag);
    exp_q.delete();
    exp_q.push_back('{200, 0, 25, 0});
    exp_q.push_back('{200, 1000, 25, 1});
    exp_q.push_back('{200, 1000, 25, 2});
    cmp_q(tag);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_report_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_width", o_meas_width, 0);
    chk("rst_period", o_meas_period, 0);
    chk("rst_cycles", o_meas_cycles, 0);
    chk("rst_index", o_meas_index, 0);
    i_rst_n = 1'b1;
    run(4, 2048);

    // square burst, all valid, then with invalid cycles interleaved
    i_threshold = 11'd100; i_report_ready = 1'b1;
    arm(3); run(5, 2048);
    chk("sq_busy_armed", o_busy, 1);
    sq_burst(1'b0); run(4, 2048);
    chk_q_const("sq");
    arm(3); run(5, 2048);
    sq_burst(1'b1); run(4, 2048);
    chk_q_const("sqtog");

    // threshold edge and report latency
    i_report_ready = 1'b0;
    arm(1); run(5, 2048); run(3, 2148); run(3, 1948); run(20, 2048);
    chk("thr_eq_quiet", o_report_valid, 0);
    chk("thr_busy", o_busy, 1);
    step(1'b1, 2149); run(GL, 2048);
    chk("lat_before", o_report_valid, 0);
    step(1'b1, 2048);
    chk("lat_valid", o_report_valid, 1);
    chk("one_width", o_meas_width, 1);
    chk("one_cycles", o_meas_cycles, 0);
    chk("one_period", o_meas_period, 0);
    chk("one_index", o_meas_index, 0);
    i_report_ready = 1'b1; step(1'b1, 2048); i_report_ready = 1'b0;
    chk("one_done", o_done, 1);
    chk("one_busy", o_busy, 0);
    chk("one_dropvalid", o_report_valid, 0);

    // short gap merges into one report
    i_report_ready = 1'b1;
    arm(1); run(5, 2048); run(10, 3000); run(GL - 1, 2048); run(10, 3000); run(30, 2048);
    exp_q.push_back('{35, 0, 0, 0});
    cmp_q("gap");
    chk("gap_done", o_done, 1);

    // backpressure with overrun
    i_report_ready = 1'b0;
    arm(2); run(5, 2048); run(10, 3000); run(20, 2048);
    chk("bp_valid", o_report_valid, 1);
    chk("bp_w0", o_meas_width, 10);
    chk("bp_ovr0", o_overrun, 0);
    run(7, 3000); run(20, 2048);
    chk("bp_ovr", o_overrun, 1);
    chk("bp_stable_w", o_meas_width, 10);
    chk("bp_stable_i", o_meas_index, 0);
    chk("bp_stable_v", o_report_valid, 1);
    i_report_ready = 1'b1; step(1'b1, 2048);
    chk("bp_released", o_report_valid, 0);
    run(12, 3000); run(20, 2048);
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_r0_w", got_q[0].w, 10);
      chk("bp_r0_i", got_q[0].i, 0);
      chk("bp_r1_w", got_q[1].w, 12);
      chk("bp_r1_i", got_q[1].i, 1);
    end
    chk("bp_done", o_done, 1);
    chk("bp_ovr_sticky", o_overrun, 1);
    arm(2); run(2, 2048);
    chk("arm_clr_ovr", o_overrun, 0);
    chk("arm_clr_done", o_done, 0);

    // randomized bursts against the model
    for (int r = 0; r < 8; r++) begin
      int thr, n;
      thr = $urandom_range(50, 500);
      n   = $urandom_range(1, 4);
      i_threshold = thr[10:0];
      i_report_ready = 1'b1;
      arm(n);
      for (int p = 0; p <= n; p++) begin
        int lead, w;
        lead = $urandom_range(1, 40);
        w    = $urandom_range(1, 40);
        for (int k = 0; k < lead; k++) step($urandom_range(0, 3) != 0, gen(thr, 1'b0));
        step(1'b1, gen(thr, 1'b1));
        for (int k = 1; k < w; k++) step($urandom_range(0, 3) != 0, gen(thr, $urandom_range(0, 4) != 0));
        for (int k = 0; k < 20; k++) step($urandom_range(0, 3) != 0, gen(thr, 1'b0));
      end
      run(GL + 20, 2048);
      run_model(thr, n);
      cmp_q($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_done", r), o_done, (exp_q.size() == n) ? 1 : 0);
    end

    // asynchronous reset mid-pulse with a report pending
    i_threshold = 11'd100; i_report_ready = 1'b0;
    arm(2); run(5, 2048); run(10, 3000); run(20, 2048); run(5, 3000);
    chk("pre_rst_valid", o_report_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_report_valid, 0);
    chk("arst_width", o_meas_width, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_index", o_meas_index, 0);
    run(3, 3000);
    chk("arst_hold_width", o_meas_width, 0);
    chk("arst_hold_period", o_meas_period, 0);
    chk("arst_hold_cycles", o_meas_cycles, 0);
    chk("arst_hold_ovr", o_overrun, 0);
    i_rst_n = 1'b1;
    run(3, 2048);
    i_report_ready = 1'b1;
    arm(1); run(5, 2048); run(8, 3000); run(20, 2048);
    exp_q.push_back('{8, 0, 0, 0});
    cmp_q("postrst");
    chk("postrst_done", o_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
